// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Launches one captured byte per frame and follows tx_busy until the frame ends.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for tx_busy low and a pending request; picks the winner
// LAUNCH    | one-cycle launch: tx_data_valid and req_ack pulse
// WAIT_BUSY | launched, waiting for the transmitter to raise tx_busy
// SENDING   | frame in flight, leaves when tx_busy falls
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4,
  localparam int ID_W  = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          tx_busy,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          tx_data_valid,
  output logic [DATA_WIDTH-1:0]         tx_parallel_data,
  output logic [ID_W-1:0]               grant_id,
  output logic                          active,
  output logic                          tx_fault
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    SENDING   = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      offset;
  logic [ID_W:0]        win_sum;
  logic [ID_W-1:0]      winner;
  logic                 found;
  logic [DATA_WIDTH-1:0] win_data;
  logic [NUM_REQ-1:0]   win_onehot;
  logic                 launch;
  logic                 fault;

  // Rotate the request vector so rr_ptr sits at bit 0; the lowest set bit wins.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NUM_REQ-1:0];
    found   = |req_rot;
    offset  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = ID_W'(k);
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (win_sum >= (ID_W+1)'(NUM_REQ)) winner = ID_W'(win_sum - (ID_W+1)'(NUM_REQ));
    else                               winner = win_sum[ID_W-1:0];
  end

  always_comb begin
    win_data   = '0;
    win_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == ID_W'(k)) begin
        win_data      = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        win_onehot[k] = 1'b1;
      end
    end
  end

  // cnt holds cycles elapsed since the LAUNCH cycle, so the fault lands
  // exactly BUSY_TIMEOUT cycles after the launch pulse.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cnt_inc    = cnt + CNT_W'(1);
    launch     = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!tx_busy && found) begin
          state_next = LAUNCH;
          launch     = 1'b1;
        end
      end
      LAUNCH: begin
        state_next = WAIT_BUSY;
        cnt_next   = cnt_inc;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = SENDING;
          cnt_next   = '0;
        end else if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
          state_next = IDLE;
          cnt_next   = '0;
          fault      = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      SENDING: begin
        if (!tx_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_data_valid    <= 1'b0;
      req_ack          <= '0;
      tx_parallel_data <= '0;
      grant_id         <= '0;
      active           <= 1'b0;
      tx_fault         <= 1'b0;
      rr_ptr           <= '0;
    end else begin
      tx_data_valid <= launch;
      req_ack       <= launch ? win_onehot : '0;
      tx_fault      <= fault;
      active        <= (state_next != IDLE);
      if (launch) begin
        tx_parallel_data <= win_data;
        grant_id         <= winner;
      end
      if (state == LAUNCH) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

endmodule
